// File: rtl/digit_entry_ctrl_pkg.sv
// Shared types and constants for the keypad digit-entry controller.
//   state_t     : controller states
//   NDIG_DEF    : default number of digit registers in the shift chain
//   TIMEOUT_DEF : default idle cycles in ENTRY/FULL before an automatic clear
//   BCD_MAX     : largest key code accepted as a digit
package digit_entry_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      FULL,
      COMMIT,
      FLUSH
   } state_t;

   localparam int          NDIG_DEF    = 4;
   localparam int          TIMEOUT_DEF = 1_000_000;
   localparam logic [3:0]  BCD_MAX     = 4'd9;

endpackage

// File: rtl/digit_entry_ctrl_idle_timer.sv
// Idle timer for the digit-entry controller.
//   clk, rst : clock, synchronous active-high reset
//   run      : high while the controller holds digits (ENTRY or FULL)
//   restart  : an accepted key; timer restarts from zero
//   expired  : high once the timer has reached TIMEOUT_CYC-1 while running
module idle_timer
   import digit_entry_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic restart,
   output logic expired
);

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   logic [TW-1:0] tmr;

   // Saturates at the terminal value; the controller leaves ENTRY/FULL the
   // cycle after expiry, which drops run and zeroes the timer.
   always_ff @(posedge clk) begin
      if (rst || !run || restart)
         tmr <= '0;
      else if (!expired)
         tmr <= tmr + TW'(1);
   end

   assign expired = run && (tmr == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/digit_entry_ctrl.sv
// Keypad digit-entry controller feeding an NDIG-deep chain of 4-bit registers.
//   clk, rst  : clock, synchronous active-high reset
//   key_valid : keypad strobe, key_code sampled with it
//   enter     : commit request
//   clear     : clear request (flushes the chain with zeros)
//   iden      : shift enable to every chain register
//   d_out     : data into the first chain register
//   count     : digits currently held
//   commit    : one-cycle pulse, chain contents are final
//   err       : one-cycle pulse, key rejected (non-BCD or chain full)
//   busy      : high while flushing
// All outputs come from flops. The one exception is iden, which is also
// gated by rst: the chain registers give iden priority over their own reset,
// so iden must already be low in the reset cycle itself.
module digit_entry_ctrl
   import digit_entry_ctrl_pkg::*;
#(
   parameter int NDIG        = NDIG_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      key_valid,
   input  logic [3:0]                key_code,
   input  logic                      enter,
   input  logic                      clear,
   output logic                      iden,
   output logic [3:0]                d_out,
   output logic [$clog2(NDIG+1)-1:0] count,
   output logic                      commit,
   output logic                      err,
   output logic                      busy
);

   localparam int CW = $clog2(NDIG + 1);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [CW-1:0] fcnt, fcnt_n;   // FLUSH cycle counter
   logic          iden_q, iden_n;
   logic [3:0]    dout_q, dout_n;
   logic          err_q, err_n;
   logic          commit_q, commit_n;
   logic          busy_q, busy_n;
   logic          restart, expired, run;

   assign run = (state == ENTRY) || (state == FULL);

   idle_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_idle_timer (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .restart (restart),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         fcnt     <= '0;
         iden_q   <= 1'b0;
         dout_q   <= 4'd0;
         err_q    <= 1'b0;
         commit_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         fcnt     <= fcnt_n;
         iden_q   <= iden_n;
         dout_q   <= dout_n;
         err_q    <= err_n;
         commit_q <= commit_n;
         busy_q   <= busy_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      fcnt_n  = fcnt;
      iden_n  = 1'b0;
      dout_n  = dout_q;
      err_n   = 1'b0;
      restart = 1'b0;

      case (state)
         IDLE, ENTRY, FULL: begin
            if (clear || expired) begin
               // First flush shift happens in the first FLUSH cycle.
               state_n = FLUSH;
               cnt_n   = '0;
               fcnt_n  = '0;
               iden_n  = 1'b1;
               dout_n  = 4'd0;
            end else if (enter && state != IDLE) begin
               // enter in IDLE (count=0) falls through, so a key strobed
               // with it is still taken.
               state_n = COMMIT;
            end else if (key_valid) begin
               if (key_code > BCD_MAX || state == FULL) begin
                  err_n = 1'b1;
               end else begin
                  iden_n  = 1'b1;
                  dout_n  = key_code;
                  cnt_n   = cnt + CW'(1);
                  restart = 1'b1;
                  state_n = (cnt == CW'(NDIG - 1)) ? FULL : ENTRY;
               end
            end
         end

         COMMIT: begin
            state_n = IDLE;
            cnt_n   = '0;
         end

         FLUSH: begin
            if (fcnt == CW'(NDIG - 1)) begin
               state_n = IDLE;
            end else begin
               fcnt_n = fcnt + CW'(1);
               iden_n = 1'b1;
               dout_n = 4'd0;
            end
         end

         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase

      commit_n = (state_n == COMMIT);
      busy_n   = (state_n == FLUSH);
   end

   assign iden   = iden_q & ~rst;
   assign d_out  = dout_q;
   assign count  = cnt;
   assign commit = commit_q;
   assign err    = err_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_digit_entry_ctrl.sv
module tb_digit_entry_ctrl;
   import digit_entry_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid, enter, clear;
   logic [3:0] key_code;
   logic       iden, commit, err, busy;
   logic [3:0] d_out;
   logic [2:0] count;

   int total = 0;
   int bad   = 0;

   digit_entry_ctrl #(
      .NDIG        (4),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .enter     (enter),
      .clear     (clear),
      .iden      (iden),
      .d_out     (d_out),
      .count     (count),
      .commit    (commit),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one key strobe for one cycle, then return to the cycle after it.
   task automatic press(input logic [3:0] code);
      key_valid = 1'b1;
      key_code  = code;
      tick();
      key_valid = 1'b0;
      key_code  = 4'd0;
   endtask

   task automatic chk_st(input string tag, input state_t exp);
      chk(tag, 32'(dut.state), 32'(exp));
   endtask

   initial begin
      rst = 1'b1; key_valid = 1'b0; key_code = 4'd0; enter = 1'b0; clear = 1'b0;
      tick(); tick();
      chk("rst_iden", 32'(iden), 0);
      chk("rst_dout", 32'(d_out), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_commit", 32'(commit), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_busy", 32'(busy), 0);
      chk_st("rst_state", IDLE);
      rst = 1'b0;
      tick();

      // Digit entry: 3,7,1 with two idle cycles after each strobe
      press(4'd3);
      chk("e1_iden", 32'(iden), 1); chk("e1_dout", 32'(d_out), 3); chk("e1_cnt", 32'(count), 1);
      tick(); chk("e1_iden_off", 32'(iden), 0);
      tick();
      press(4'd7);
      chk("e2_iden", 32'(iden), 1); chk("e2_dout", 32'(d_out), 7); chk("e2_cnt", 32'(count), 2);
      tick(); chk("e2_iden_off", 32'(iden), 0);
      tick();
      press(4'd1);
      chk("e3_iden", 32'(iden), 1); chk("e3_dout", 32'(d_out), 1); chk("e3_cnt", 32'(count), 3);
      tick(); chk("e3_iden_off", 32'(iden), 0);
      chk("e_count", 32'(count), 3);
      chk_st("e_state", ENTRY);

      // Back to IDLE through a plain clear
      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("c_busy", 32'(busy), 1); chk("c_iden", 32'(iden), 1);
         tick();
      end
      chk("c_done_busy", 32'(busy), 0); chk("c_done_iden", 32'(iden), 0);

      // Full chain: 1..4 accepted, 5 rejected
      for (int k = 1; k <= 4; k++) begin
         press(4'(k));
         chk("f_iden", 32'(iden), 1); chk("f_dout", 32'(d_out), 32'(k)); chk("f_cnt", 32'(count), 32'(k));
      end
      chk_st("f_state", FULL);
      press(4'd5);
      chk("f5_err", 32'(err), 1); chk("f5_iden", 32'(iden), 0); chk("f5_cnt", 32'(count), 4);
      tick(); chk("f5_err_off", 32'(err), 0);
      enter = 1'b1; tick(); enter = 1'b0;
      chk("f_commit", 32'(commit), 1); chk("f_commit_iden", 32'(iden), 0);
      tick();
      chk("f_commit_off", 32'(commit), 0); chk("f_cnt0", 32'(count), 0);

      // Commit of 9,0 and empty enter
      press(4'd9); press(4'd0);
      chk("m_cnt", 32'(count), 2); chk("m_dout", 32'(d_out), 0);
      enter = 1'b1; tick(); enter = 1'b0;
      chk("m_commit", 32'(commit), 1); chk("m_iden", 32'(iden), 0);
      tick();
      chk("m_commit_off", 32'(commit), 0); chk("m_cnt0", 32'(count), 0); chk("m_iden2", 32'(iden), 0);
      chk_st("m_state", IDLE);
      enter = 1'b1; tick(); enter = 1'b0;
      chk("ie_commit", 32'(commit), 0); chk("ie_err", 32'(err), 0); chk_st("ie_state", IDLE);

      // Clear wins over enter and key; key during FLUSH is dropped
      press(4'd5);
      clear = 1'b1; enter = 1'b1; key_valid = 1'b1; key_code = 4'd2;
      tick();
      clear = 1'b0; enter = 1'b0; key_valid = 1'b0; key_code = 4'd0;
      for (int i = 0; i < 4; i++) begin
         chk("t_busy", 32'(busy), 1); chk("t_iden", 32'(iden), 1); chk("t_dout", 32'(d_out), 0);
         chk("t_commit", 32'(commit), 0); chk("t_err", 32'(err), 0); chk("t_cnt", 32'(count), 0);
         if (i == 1) begin key_valid = 1'b1; key_code = 4'd3; end
         tick();
         key_valid = 1'b0; key_code = 4'd0;
      end
      chk("t_end_busy", 32'(busy), 0); chk("t_end_iden", 32'(iden), 0);
      chk("t_end_cnt", 32'(count), 0); chk_st("t_end_state", IDLE);

      // Timeout: strobe is cycle 0, flush must begin on cycle 17
      press(4'd6);
      chk("to_c1_busy", 32'(busy), 0);
      for (int c = 2; c <= 16; c++) begin
         tick();
         chk("to_wait_busy", 32'(busy), 0);
      end
      tick();
      chk("to_c17_busy", 32'(busy), 1); chk("to_c17_iden", 32'(iden), 1); chk("to_c17_cnt", 32'(count), 0);
      tick(); tick(); tick(); tick();
      chk("to_end_busy", 32'(busy), 0); chk_st("to_end_state", IDLE);

      // Bad key code
      press(4'd12);
      chk("bk_err", 32'(err), 1); chk("bk_iden", 32'(iden), 0); chk("bk_cnt", 32'(count), 0);

      // Reset during the second FLUSH cycle
      tick();
      clear = 1'b1; tick(); clear = 1'b0;
      chk("rf_f1_iden", 32'(iden), 1);
      tick();
      chk("rf_f2_iden_pre", 32'(iden), 1);
      rst = 1'b1; #1;
      chk("rf_f2_iden_rst", 32'(iden), 0);
      tick();
      rst = 1'b0; #1;
      chk("rf_iden", 32'(iden), 0); chk("rf_busy", 32'(busy), 0); chk("rf_cnt", 32'(count), 0);
      chk("rf_dout", 32'(d_out), 0); chk("rf_commit", 32'(commit), 0); chk("rf_err", 32'(err), 0);
      chk_st("rf_state", IDLE);
      tick();
      chk("rf_after_iden", 32'(iden), 0); chk("rf_after_busy", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
